// File: rtl/data_mem_responder.sv
// Purpose : MEM-stage data memory with a posted write buffer and same-cycle load forwarding.
// Latency : loads are combinational (zero cycles); stores are posted and reach RAM when drained.
// Backpr. : none; a full buffer is force-drained on the same edge as an enqueue, so stores are never refused.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      asynchronous active-low reset (buffer pointers, count, error flags)
//   daddrbus   byte address; word index is daddrbus[ADDR_W+2:3]
//   databus    store data in (SW), load data out (LW without SW), otherwise released
//   SW, LW     store / load strobes
//   wb_count   occupied write-buffer entries; wb_empty when zero
//   err_align  sticky: access with nonzero byte offset
//   err_range  sticky: access above the RAM's address range
//   err_proto  sticky: SW and LW high together
module data_mem_responder #(
  parameter int ADDR_W   = 10,
  parameter int WB_DEPTH = 4   // power of two, >= 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               daddrbus,
  inout  wire  [63:0]               databus,
  input  logic                      SW,
  input  logic                      LW,
  output logic [$clog2(WB_DEPTH):0] wb_count,
  output logic                      wb_empty,
  output logic                      err_align,
  output logic                      err_range,
  output logic                      err_proto
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage: RAM and buffer payload carry no reset.
  logic [63:0]       mem    [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wb_idx [0:WB_DEPTH-1];
  logic [63:0]       wb_dat [0:WB_DEPTH-1];

  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;

  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              enq;
  logic              drain;
  logic              full;
  logic              ld_act;
  logic              fwd_hit;
  logic [63:0]       fwd_dat;
  logic [PTR_W-1:0]  slot;
  logic [63:0]       rd_data;

  assign idx      = daddrbus[ADDR_W+2:3];
  assign in_range = (daddrbus[63:ADDR_W+3] == '0);
  assign full     = (count == CNT_W'(WB_DEPTH));
  // Out-of-range stores are dropped rather than aliased onto a real word.
  assign enq      = SW && in_range;
  // A load keeps the buffer from draining (the RAM read port stays with the
  // load) unless the buffer is full, in which case the head is forced out so
  // an enqueue on the same edge still fits.
  assign drain    = (count != '0) && (!LW || full);
  // SW+LW is treated as a store, so the bus stays with the CPU.
  assign ld_act   = LW && !SW;

  // Walk the live entries oldest->youngest; the last match wins so the
  // youngest store to this word is forwarded. An entry draining on the
  // coming edge is still visible here, and its data equals what RAM gets.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_dat = '0;
    slot    = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (wb_idx[slot] == idx)) begin
        fwd_hit = 1'b1;
        fwd_dat = wb_dat[slot];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (in_range) begin
      rd_data = fwd_hit ? fwd_dat : mem[idx];
    end
  end

  assign databus = (reset && ld_act) ? rd_data : 'z;

  // Pointers, occupancy and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      err_align <= 1'b0;
      err_range <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      if (enq)   tail <= tail + PTR_W'(1);
      if (drain) head <= head + PTR_W'(1);
      count <= count + CNT_W'(enq) - CNT_W'(drain);
      if ((SW || LW) && (daddrbus[2:0] != 3'b000)) err_align <= 1'b1;
      if ((SW || LW) && !in_range)                 err_range <= 1'b1;
      if (SW && LW)                                err_proto <= 1'b1;
    end
  end

  // Payload writes. When full, tail==head: the drain reads the old head
  // entry while the enqueue overwrites that slot on the same edge.
  // drain is derived from count, which reset clears asynchronously, so no
  // RAM write can happen while reset is held.
  always_ff @(posedge clk) begin
    if (enq) begin
      wb_idx[tail] <= idx;
      wb_dat[tail] <= databus;
    end
    if (drain) begin
      mem[wb_idx[head]] <= wb_dat[head];
    end
  end

  assign wb_count = count;
  assign wb_empty = (count == '0);

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose : directed bench for data_mem_responder with a load-data scoreboard.
// Latency : loads checked 1 ns after inputs change; registered state checked 1 ns after the edge.
// Backpr. : n/a (bench).
module tb_data_mem_responder;

  localparam int ADDR_W   = 10;
  localparam int WB_DEPTH = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [63:0]               daddrbus;
  wire  [63:0]               databus;
  logic                      SW, LW;
  logic [$clog2(WB_DEPTH):0] wb_count;
  logic                      wb_empty, err_align, err_range, err_proto;

  logic [63:0] tb_dat;
  logic        tb_drv;
  assign databus = tb_drv ? tb_dat : 'z;

  data_mem_responder #(.ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH)) dut (
    .clk(clk), .reset(reset), .daddrbus(daddrbus), .databus(databus),
    .SW(SW), .LW(LW), .wb_count(wb_count), .wb_empty(wb_empty),
    .err_align(err_align), .err_range(err_range), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  // Architectural memory image, keyed by word address (addr >> 3).
  logic [63:0] model [logic [63:0]];
  logic [63:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // A released bus reads Z (4-state) or 0 (2-state); any driven
  // nonzero value means the responder grabbed the bus.
  task automatic chk_z(input string tag);
    vectors++;
    assert ((databus === 64'hz) || (databus === 64'h0)) else begin
      fails++;
      $error("FAIL %s: got %h want released bus (Z)", tag, databus);
    end
  endtask

  task automatic chk_cnt(input string tag, input int exp);
    chk(tag, 64'(wb_count), 64'(exp));
  endtask

  task automatic chk_flags(input string tag, input logic a, input logic r, input logic p);
    chk({tag, "_align"}, 64'(err_align), 64'(a));
    chk({tag, "_range"}, 64'(err_range), 64'(r));
    chk({tag, "_proto"}, 64'(err_proto), 64'(p));
  endtask

  // One bus cycle: drive at negedge, check the combinational bus, then
  // step past the rising edge so callers can check registered state.
  task automatic cyc(input string tag, input logic sw, input logic lw,
                     input logic [63:0] addr, input logic [63:0] dat);
    logic [63:0] hi;
    logic [63:0] exp;
    @(negedge clk);
    SW = sw; LW = lw; daddrbus = addr; tb_drv = sw; tb_dat = dat;
    hi = addr >> (ADDR_W + 3);
    if (sw && hi == 64'h0) model[addr >> 3] = dat;
    if (lw && !sw) begin
      exp = 64'h0;
      if (hi == 64'h0 && model.exists(addr >> 3)) exp = model[addr >> 3];
      exp_q.push_back(exp);
    end
    #1;
    if (lw && !sw)  chk(tag, databus, exp_q.pop_front());
    else if (sw)    chk({tag, "_bus"}, databus, dat);
    else            chk_z({tag, "_z"});
    @(posedge clk);
    #1;
  endtask

  logic [63:0] old8, old18, old20;

  initial begin
    reset = 1'b0; SW = 1'b0; LW = 1'b0; daddrbus = '0; tb_drv = 1'b0; tb_dat = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt("rst_cnt", 0);
    chk("rst_empty", 64'(wb_empty), 64'h1);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk) reset = 1'b1;

    // Known contents at word 0 for the later loads of 0x0.
    cyc("st00", 1, 0, 64'h0, 64'h5A5A_5A5A);
    chk_cnt("st00_cnt", 1);
    cyc("idle0", 0, 0, 64'h0, 64'h0);
    chk_cnt("idle0_cnt", 0);

    // Single store, drain on idle, load from RAM.
    cyc("st10", 1, 0, 64'h10, 64'hAAAA);
    chk_cnt("st10_cnt", 1);
    chk("st10_empty", 64'(wb_empty), 64'h0);
    cyc("idle10", 0, 0, 64'h10, 64'h0);
    chk_cnt("idle10_cnt", 0);
    chk("idle10_empty", 64'(wb_empty), 64'h1);
    cyc("ld10", 0, 1, 64'h10, 64'h0);

    // Back-to-back stores to one word: the second edge drains the first,
    // so the load sees RAM=1 but must forward the buffered 2.
    cyc("st20a", 1, 0, 64'h20, 64'h1);
    chk_cnt("st20a_cnt", 1);
    cyc("st20b", 1, 0, 64'h20, 64'h2);
    chk_cnt("st20b_cnt", 1);
    cyc("ld20_fwd", 0, 1, 64'h20, 64'h0);
    chk_cnt("ld20_cnt", 1);
    cyc("idle20", 0, 0, 64'h20, 64'h0);
    chk_cnt("idle20_cnt", 0);
    cyc("ld20_ram", 0, 1, 64'h20, 64'h0);

    // LW held for 8 cycles; stores ride as SW+LW so the buffer fills.
    chk("pre_proto", 64'(err_proto), 64'h0);
    for (int i = 1; i <= 5; i++) begin
      cyc("sl", 1, 1, 64'(i * 8), 64'h1000 + 64'(i * 8));
      chk_cnt("sl_cnt", (i < 4) ? i : 4);
    end
    chk("sl_proto", 64'(err_proto), 64'h1);
    cyc("ld00_a", 0, 1, 64'h0, 64'h0);
    chk_cnt("ld00_a_cnt", 3);
    cyc("ld28_fwd", 0, 1, 64'h28, 64'h0);
    chk_cnt("ld28_cnt", 3);
    cyc("ld00_b", 0, 1, 64'h0, 64'h0);
    chk_cnt("ld00_b_cnt", 3);
    for (int i = 0; i < 3; i++) begin
      cyc("drain", 0, 0, 64'h28, 64'h0);
      chk_cnt("drain_cnt", 2 - i);
    end
    for (int i = 1; i <= 5; i++) cyc("ld_fill", 0, 1, 64'(i * 8), 64'h0);

    // Misaligned store lands on word 2; out-of-range store is dropped.
    chk("pre_align", 64'(err_align), 64'h0);
    cyc("st13", 1, 0, 64'h13, 64'h1313);
    chk("st13_align", 64'(err_align), 64'h1);
    chk_cnt("st13_cnt", 1);
    cyc("idle13", 0, 0, 64'h10, 64'h0);
    cyc("ld10_al", 0, 1, 64'h10, 64'h0);
    chk("pre_range", 64'(err_range), 64'h0);
    cyc("st_oor", 1, 0, 64'h1_0000_0000, 64'hBAD);
    chk("oor_range", 64'(err_range), 64'h1);
    chk_cnt("oor_cnt", 0);
    cyc("ld_oor", 0, 1, 64'h1_0000_0000, 64'h0);
    cyc("ld00_c", 0, 1, 64'h0, 64'h0);

    // Three pending stores, then reset lands mid-cycle.
    old8 = model[64'h1]; old18 = model[64'h3]; old20 = model[64'h4];
    cyc("rs08", 1, 1, 64'h8,  64'hF1);
    cyc("rs18", 1, 1, 64'h18, 64'hF3);
    cyc("rs20", 1, 1, 64'h20, 64'hF4);
    chk_cnt("rs_pend_cnt", 3);
    @(negedge clk);
    SW = 1'b0; LW = 1'b0; tb_drv = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk_cnt("rs_cnt", 0);
    chk("rs_empty", 64'(wb_empty), 64'h1);
    chk_flags("rs", 1'b0, 1'b0, 1'b0);
    @(negedge clk) reset = 1'b1;
    model[64'h1] = old8; model[64'h3] = old18; model[64'h4] = old20;
    cyc("post_idle", 0, 0, 64'h8, 64'h0);
    chk_cnt("post_cnt", 0);
    cyc("post_ld08", 0, 1, 64'h8,  64'h0);
    cyc("post_ld18", 0, 1, 64'h18, 64'h0);
    cyc("post_ld20", 0, 1, 64'h20, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within budget");
    $fatal(1, "timeout");
  end

endmodule
